// File: rtl/vm_pkg.sv
// Shared types and constants for the 15c vending machine controller.
// The optional cancel/refund feature is enabled by defining VM_CANCEL_EN.
package vm_pkg;

  localparam int CREDIT_W = 5;

  localparam logic [CREDIT_W-1:0] PRICE   = 5'd15;
  localparam logic [CREDIT_W-1:0] COIN_5  = 5'd5;
  localparam logic [CREDIT_W-1:0] COIN_10 = 5'd10;
  localparam logic [CREDIT_W-1:0] CHANGE  = 5'd5;

  // Code 2'b11 is illegal unless it is taken by the refund state
  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
`ifdef VM_CANCEL_EN
    S10 = 2'b10,
    REFUND = 2'b11
`else
    S10 = 2'b10
`endif
  } state_t;

  function automatic logic [CREDIT_W-1:0] credit_of(input state_t st);
    case (st)
      S5:      credit_of = COIN_5;
      S10:     credit_of = COIN_10;
      default: credit_of = '0;
    endcase
  endfunction

  function automatic state_t state_of(input logic [CREDIT_W-1:0] credit);
    case (credit)
      COIN_5:  state_of = S5;
      COIN_10: state_of = S10;
      default: state_of = S0;
    endcase
  endfunction

endpackage

// File: rtl/vm_credit_calc.sv
// Combinational next-state and output decode for the vending machine.
// With VM_CANCEL_EN defined, also decodes cancel into refund pulses.
module vm_credit_calc
  import vm_pkg::*;
(
  input  state_t state,
  input  logic   coin_5,
  input  logic   coin_10,
`ifdef VM_CANCEL_EN
  input  logic   cancel,
  output logic   refund_nxt,
`endif
  output state_t next_state,
  output logic   dispense_nxt,
  output logic   change_nxt
);

  logic [CREDIT_W-1:0] added;
  logic [CREDIT_W-1:0] total;
  logic                legal;

  always_comb begin
    added = (coin_5 ? COIN_5 : '0) + (coin_10 ? COIN_10 : '0);
    legal = (state == S0) || (state == S5) || (state == S10);
    total = credit_of(state) + added;
  end

  always_comb begin
    next_state   = S0;
    dispense_nxt = 1'b0;
    change_nxt   = 1'b0;
`ifdef VM_CANCEL_EN
    refund_nxt   = 1'b0;
    if (state == REFUND) begin
      // Second refund coin; coins are ignored while it is paid out
      refund_nxt = 1'b1;
    end else if (cancel && !coin_5 && !coin_10) begin
      if (state == S5) begin
        refund_nxt = 1'b1;
      end else if (state == S10) begin
        next_state = REFUND;
        refund_nxt = 1'b1;
      end
    end else
`endif
    if (legal) begin
      if (total < PRICE) begin
        next_state = state_of(total);
      end else if (total == PRICE) begin
        dispense_nxt = 1'b1;
      end else begin
        // Only one change coin is returned; any excess stays as credit
        dispense_nxt = 1'b1;
        change_nxt   = 1'b1;
        next_state   = state_of(total - PRICE - CHANGE);
      end
    end
  end

endmodule

// File: rtl/vending_machine.sv
// 15c single-product vending machine: state and registered output pulses.
// Define VM_CANCEL_EN to add the cancel input and refund_5 output.
module vending_machine
  import vm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic coin_5,
  input  logic coin_10,
`ifdef VM_CANCEL_EN
  input  logic cancel,
  output logic refund_5,
`endif
  output logic dispense,
  output logic change_5
);

  state_t state;
  state_t next_state;
  logic   dispense_nxt;
  logic   change_nxt;
`ifdef VM_CANCEL_EN
  logic   refund_nxt;
`endif

  vm_credit_calc u_calc (
    .state        (state),
    .coin_5       (coin_5),
    .coin_10      (coin_10),
`ifdef VM_CANCEL_EN
    .cancel       (cancel),
    .refund_nxt   (refund_nxt),
`endif
    .next_state   (next_state),
    .dispense_nxt (dispense_nxt),
    .change_nxt   (change_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S0;
      dispense <= 1'b0;
      change_5 <= 1'b0;
`ifdef VM_CANCEL_EN
      refund_5 <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      dispense <= dispense_nxt;
      change_5 <= change_nxt;
`ifdef VM_CANCEL_EN
      refund_5 <= refund_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: stimulus pushes expected outputs, a monitor pops and checks.
module tb_vending_machine;
  import vm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coin_5 = 1'b0;
  logic coin_10 = 1'b0;
  logic cancel = 1'b0;
  logic dispense;
  logic change_5;
  logic refund_5;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic   d;
    logic   c;
    logic   r;
    state_t st;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

`ifndef VM_CANCEL_EN
  assign refund_5 = 1'b0;
`endif

  vending_machine dut (
    .clk      (clk),
    .reset    (reset),
    .coin_5   (coin_5),
    .coin_10  (coin_10),
`ifdef VM_CANCEL_EN
    .cancel   (cancel),
    .refund_5 (refund_5),
`endif
    .dispense (dispense),
    .change_5 (change_5)
  );

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of coins at the falling edge and queue the expected result of the next rising edge
  task automatic cyc(input logic c5, input logic c10, input logic cn,
                     input logic ed, input logic ec, input logic er, input state_t est);
    exp_t e;
    @(negedge clk);
    coin_5  = c5;
    coin_10 = c10;
    cancel  = cn;
    e.d = ed; e.c = ec; e.r = er; e.st = est;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dispense", {1'b0, dispense}, {1'b0, e.d});
        chk("change_5", {1'b0, change_5}, {1'b0, e.c});
        chk("state", dut.state, e.st);
`ifdef VM_CANCEL_EN
        chk("refund_5", {1'b0, refund_5}, {1'b0, e.r});
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1 reset = 1'b0;
    // Reset held with coins toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      coin_5  = i[0];
      coin_10 = i[1];
      @(posedge clk);
      #1;
      chk("rst_dispense", {1'b0, dispense}, 2'b00);
      chk("rst_change", {1'b0, change_5}, 2'b00);
      chk("rst_state", dut.state, S0);
    end
    @(negedge clk);
    coin_5 = 1'b0; coin_10 = 1'b0;
    reset = 1'b1;

    cyc(0, 0, 0, 0, 0, 0, S0);
    cyc(0, 0, 0, 0, 0, 0, S0);
    // 5 + 10
    cyc(1, 0, 0, 0, 0, 0, S5);
    cyc(0, 1, 0, 1, 0, 0, S0);
    cyc(0, 0, 0, 0, 0, 0, S0);
    // 10 + 10 -> change
    cyc(0, 1, 0, 0, 0, 0, S10);
    cyc(0, 1, 0, 1, 1, 0, S0);
    cyc(0, 0, 0, 0, 0, 0, S0);
    // 5 x3, then both coins from empty
    cyc(1, 0, 0, 0, 0, 0, S5);
    cyc(1, 0, 0, 0, 0, 0, S10);
    cyc(1, 0, 0, 1, 0, 0, S0);
    cyc(1, 1, 0, 1, 0, 0, S0);
    cyc(0, 0, 0, 0, 0, 0, S0);
    // S10 + both -> change and 5c credit kept
    cyc(0, 1, 0, 0, 0, 0, S10);
    cyc(1, 1, 0, 1, 1, 0, S5);
    cyc(0, 1, 0, 1, 0, 0, S0);
    cyc(0, 0, 0, 0, 0, 0, S0);
    // Back-to-back sales
    cyc(1, 1, 0, 1, 0, 0, S0);
    cyc(1, 1, 0, 1, 0, 0, S0);
    cyc(0, 0, 0, 0, 0, 0, S0);

    // Async reset while dispense is high
    cyc(1, 0, 0, 0, 0, 0, S5);
    cyc(0, 1, 0, 1, 0, 0, S0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_dispense", {1'b0, dispense}, 2'b00);
    @(negedge clk);
    coin_5 = 1'b0; coin_10 = 1'b0;
    reset = 1'b1;

    // Async reset mid-transaction discards credit
    cyc(0, 1, 0, 0, 0, 0, S10);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_state", dut.state, S0);
    chk("async_rst_change", {1'b0, change_5}, 2'b00);
    @(negedge clk);
    coin_5 = 1'b0; coin_10 = 1'b0;
    reset = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, S5);
    cyc(0, 0, 0, 0, 0, 0, S5);
    cyc(0, 1, 0, 1, 0, 0, S0);
    cyc(0, 0, 0, 0, 0, 0, S0);

`ifdef VM_CANCEL_EN
    // Cancel from S10: two refund pulses
    cyc(0, 1, 0, 0, 0, 0, S10);
    cyc(0, 0, 1, 0, 0, 1, REFUND);
    cyc(0, 0, 0, 0, 0, 1, S0);
    cyc(0, 0, 0, 0, 0, 0, S0);
    // Cancel from S5: one pulse; cancel at S0 does nothing
    cyc(1, 0, 0, 0, 0, 0, S5);
    cyc(0, 0, 1, 0, 0, 1, S0);
    cyc(0, 0, 1, 0, 0, 0, S0);
    // Coin beats cancel
    cyc(1, 0, 1, 0, 0, 0, S5);
    cyc(0, 1, 1, 1, 0, 0, S0);
    // Coins ignored during REFUND
    cyc(0, 1, 0, 0, 0, 0, S10);
    cyc(0, 0, 1, 0, 0, 1, REFUND);
    cyc(0, 1, 0, 0, 0, 1, S0);
    cyc(0, 0, 0, 0, 0, 0, S0);
`endif

    @(negedge clk);
    coin_5 = 1'b0; coin_10 = 1'b0; cancel = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
